// File: rtl/placement_cost_eval_if.sv
// Memory-side bus of the placement cost evaluator: edge ROM pair plus shared X/Y position RAM port.
// The evaluator is the master; the memories (or a testbench model) sit on the slave side.
interface placement_cost_eval_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic                 ea_re;
  logic                 eb_re;
  logic [AW-1:0]        e_addr;
  logic [DW-1:0]        ea_data;
  logic [DW-1:0]        eb_data;
  logic                 p_re;
  logic [AW-1:0]        p_addr;
  logic signed [DW-1:0] px_data;
  logic signed [DW-1:0] py_data;

  modport master (
    output ea_re, eb_re, e_addr, p_re, p_addr,
    input  ea_data, eb_data, px_data, py_data
  );

  modport slave (
    input  ea_re, eb_re, e_addr, p_re, p_addr,
    output ea_data, eb_data, px_data, py_data
  );
endinterface

// File: rtl/placement_cost_eval.sv
// Walks the edge list after placement and accumulates Manhattan and 1-hop routing costs.
// One edge per 5 cycles; an unplaced endpoint (-1) aborts with a sticky error.
module placement_cost_eval #(
  parameter int N_EDGE = 142,
  parameter int DW     = 32,
  parameter int AW     = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  placement_cost_eval_if.master mem,
  output logic signed [DW-1:0] sum_o,
  output logic signed [DW-1:0] sum_1hop_o,
  output logic [DW-1:0]        cycles_o
);

  localparam logic [AW-1:0] LastIdx = AW'(N_EDGE > 0 ? N_EDGE - 1 : 0);
  localparam logic [DW-1:0] One     = DW'(1);

  typedef enum logic [2:0] {
    StIdle, StEdge, StPosA, StPosB, StCalc, StAcc, StDone
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        i_q, i_d;
  logic [AW-1:0]        b_id_q, b_id_d;
  logic signed [DW-1:0] ax_q, ax_d, ay_q, ay_d;
  logic [DW-1:0]        dx_q, dx_d, dy_q, dy_d;
  logic [DW-1:0]        sum_q, sum_d, hop_q, hop_d, cyc_q, cyc_d;
  logic                 err_q, err_d;

  logic signed [DW-1:0] diff_x, diff_y;
  logic [DW-1:0]        hop_x, hop_y;
  logic                 unplaced;

  assign busy_o     = (state_q != StIdle) && (state_q != StDone);
  assign done_o     = (state_q == StDone);
  assign err_o      = err_q;
  assign sum_o      = sum_q;
  assign sum_1hop_o = hop_q;
  assign cycles_o   = cyc_q;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    b_id_d  = b_id_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sum_d   = sum_q;
    hop_d   = hop_q;
    cyc_d   = cyc_q;
    err_d   = err_q;

    mem.ea_re  = 1'b0;
    mem.eb_re  = 1'b0;
    mem.e_addr = '0;
    mem.p_re   = 1'b0;
    mem.p_addr = '0;

    // In CALC the position port returns endpoint B.
    diff_x   = ax_q - mem.px_data;
    diff_y   = ay_q - mem.py_data;
    unplaced = (ax_q == '1) || (ay_q == '1) || (mem.px_data == '1) || (mem.py_data == '1);
    hop_x    = (dx_q >> 1) + {{(DW-1){1'b0}}, dx_q[0]};
    hop_y    = (dy_q >> 1) + {{(DW-1){1'b0}}, dy_q[0]};

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sum_d   = '0;
          hop_d   = '0;
          cyc_d   = '0;
          err_d   = 1'b0;
          i_d     = '0;
          state_d = (N_EDGE == 0) ? StDone : StEdge;
        end
      end
      StEdge: begin
        mem.ea_re  = 1'b1;
        mem.eb_re  = 1'b1;
        mem.e_addr = i_q;
        state_d    = StPosA;
      end
      StPosA: begin
        b_id_d     = AW'(mem.eb_data);
        mem.p_re   = 1'b1;
        mem.p_addr = AW'(mem.ea_data);
        state_d    = StPosB;
      end
      StPosB: begin
        ax_d       = mem.px_data;
        ay_d       = mem.py_data;
        mem.p_re   = 1'b1;
        mem.p_addr = b_id_q;
        state_d    = StCalc;
      end
      StCalc: begin
        if (unplaced) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          dx_d    = diff_x[DW-1] ? -diff_x : diff_x;
          dy_d    = diff_y[DW-1] ? -diff_y : diff_y;
          state_d = StAcc;
        end
      end
      StAcc: begin
        sum_d   = sum_q + dx_q + dy_q - One;
        hop_d   = hop_q + hop_x + hop_y - One;
        i_d     = i_q + AW'(1);
        state_d = (i_q == LastIdx) ? StDone : StEdge;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (busy_o) cyc_d = cyc_q + One;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      i_q     <= '0;
      b_id_q  <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sum_q   <= '0;
      hop_q   <= '0;
      cyc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      b_id_q  <= b_id_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sum_q   <= sum_d;
      hop_q   <= hop_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_placement_cost_eval.sv
// Bench for placement_cost_eval: five instances with different edge counts share one memory image;
// directed vectors, reset/restart sequences and randomized runs against an arithmetic cost model.
module tb_placement_cost_eval;

  localparam int NUM = 5;

  function automatic int n_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      2:       return 3;
      3:       return 0;
      default: return 12;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int ea_mem [16];
  int eb_mem [16];
  int px_mem [16];
  int py_mem [16];

  logic        start_v [NUM];
  logic        busy_v  [NUM];
  logic        done_v  [NUM];
  logic        err_v   [NUM];
  logic [31:0] sum_v   [NUM];
  logic [31:0] hop_v   [NUM];
  logic [31:0] cyc_v   [NUM];
  logic        pre_v   [NUM];
  logic        ere_v   [NUM];
  logic [31:0] pa_v    [NUM];
  logic [31:0] ea_v    [NUM];

  for (genvar g = 0; g < NUM; g++) begin : g_dut
    placement_cost_eval_if #(.DW(32), .AW(32)) bus ();

    placement_cost_eval #(.N_EDGE(n_of(g)), .DW(32), .AW(32)) u_dut (
      .clk_i      (clk),
      .reset_ni   (rst_n),
      .start_i    (start_v[g]),
      .busy_o     (busy_v[g]),
      .done_o     (done_v[g]),
      .err_o      (err_v[g]),
      .mem        (bus),
      .sum_o      (sum_v[g]),
      .sum_1hop_o (hop_v[g]),
      .cycles_o   (cyc_v[g])
    );

    assign pre_v[g] = bus.p_re;
    assign ere_v[g] = bus.ea_re | bus.eb_re;
    assign pa_v[g]  = bus.p_addr;
    assign ea_v[g]  = bus.e_addr;

    always_ff @(posedge clk) begin
      if (bus.ea_re) bus.ea_data <= ea_mem[bus.e_addr[3:0]];
      if (bus.eb_re) bus.eb_data <= eb_mem[bus.e_addr[3:0]];
      if (bus.p_re) begin
        bus.px_data <= px_mem[bus.p_addr[3:0]];
        bus.py_data <= py_mem[bus.p_addr[3:0]];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  // Pulses start on instance d; optionally re-pulses start at cycle `repulse`. Returns cycles to done.
  task automatic run_eval(input int d, input int repulse, output int lat);
    @(negedge clk);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    lat = 1;
    while (!done_v[d] && lat < 1000) begin
      start_v[d] = (lat == repulse);
      @(negedge clk);
      lat++;
    end
    start_v[d] = 1'b0;
    if (!done_v[d]) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: instance %0d gave no done within %0d cycles", d, lat);
    end
  endtask

  // Cost model straight from the edge/position tables.
  task automatic model(input int n, output logic [31:0] es, output logic [31:0] eh,
                       output logic [31:0] ec, output logic ee, output int elat);
    longint s = 0;
    longint h = 0;
    ee   = 1'b0;
    elat = 5 * n + 1;
    ec   = 32'(5 * n);
    for (int k = 0; k < n; k++) begin
      int a = ea_mem[k];
      int b = eb_mem[k];
      longint ax = px_mem[a[3:0]];
      longint ay = py_mem[a[3:0]];
      longint bx = px_mem[b[3:0]];
      longint by = py_mem[b[3:0]];
      longint dx, dy;
      if (ax == -1 || ay == -1 || bx == -1 || by == -1) begin
        ee   = 1'b1;
        elat = 5 * k + 5;
        ec   = 32'(5 * k + 4);
        break;
      end
      dx = (ax > bx) ? ax - bx : bx - ax;
      dy = (ay > by) ? ay - by : by - ay;
      s += dx + dy - 1;
      h += (dx + 1) / 2 + (dy + 1) / 2 - 1;
    end
    es = s[31:0];
    eh = h[31:0];
  endtask

  typedef struct {
    int                d;
    logic [2:0][7:0]   ea;
    logic [2:0][7:0]   eb;
    logic [3:0][7:0]   px;
    logic [3:0][7:0]   py;
    logic [31:0]       s;
    logic [31:0]       h;
    logic [31:0]       c;
    logic              e;
    int                lat;
  } vec_t;

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < 16; k++) begin
      ea_mem[k] = 0;
      eb_mem[k] = 0;
      px_mem[k] = 0;
      py_mem[k] = 0;
    end
    for (int k = 0; k < 3; k++) begin
      ea_mem[k] = int'(v.ea[k]);
      eb_mem[k] = int'(v.eb[k]);
    end
    for (int j = 0; j < 4; j++) begin
      px_mem[j] = $signed(v.px[j]);
      py_mem[j] = $signed(v.py[j]);
    end
  endtask

  vec_t vecs [7];

  initial begin
    int          lat;
    int          dcount;
    logic [31:0] es, eh, ec;
    logic        ee;
    int          elat;

    for (int g = 0; g < NUM; g++) start_v[g] = 1'b0;

    vecs[0] = '{d: 0, ea: {8'd0, 8'd1, 8'd0}, eb: {8'd0, 8'd2, 8'd1},
                px: {8'd0, 8'd3, 8'd3, 8'd0}, py: {8'd0, 8'd3, 8'd2, 8'd0},
                s: 32'd4, h: 32'd2, c: 32'd10, e: 1'b0, lat: 11};
    vecs[1] = '{d: 1, ea: {8'd0, 8'd0, 8'd0}, eb: {8'd0, 8'd0, 8'd1},
                px: {8'd0, 8'd0, 8'd5, 8'd5}, py: {8'd0, 8'd0, 8'd5, 8'd5},
                s: 32'hFFFF_FFFF, h: 32'hFFFF_FFFF, c: 32'd5, e: 1'b0, lat: 6};
    vecs[2] = '{d: 1, ea: {8'd0, 8'd0, 8'd0}, eb: {8'd0, 8'd0, 8'd1},
                px: {8'd0, 8'd0, 8'd7, 8'd0}, py: {8'd0, 8'd0, 8'd0, 8'd0},
                s: 32'd6, h: 32'd3, c: 32'd5, e: 1'b0, lat: 6};
    vecs[3] = '{d: 2, ea: {8'd2, 8'd1, 8'd0}, eb: {8'd3, 8'd2, 8'd1},
                px: {8'd0, 8'hFF, 8'd3, 8'd0}, py: {8'd0, 8'd3, 8'd2, 8'd0},
                s: 32'd4, h: 32'd2, c: 32'd9, e: 1'b1, lat: 10};
    vecs[4] = '{d: 3, ea: {8'd0, 8'd0, 8'd0}, eb: {8'd0, 8'd0, 8'd1},
                px: {8'd0, 8'd0, 8'd9, 8'd1}, py: {8'd0, 8'd0, 8'd9, 8'd1},
                s: 32'd0, h: 32'd0, c: 32'd0, e: 1'b0, lat: 1};
    vecs[5] = '{d: 0, ea: {8'd0, 8'd1, 8'd0}, eb: {8'd0, 8'd0, 8'd1},
                px: {8'd0, 8'd0, 8'd2, 8'hFC}, py: {8'd0, 8'd0, 8'hFB, 8'd3},
                s: 32'd26, h: 32'd12, c: 32'd10, e: 1'b0, lat: 11};
    vecs[6] = '{d: 2, ea: {8'd2, 8'd1, 8'd0}, eb: {8'd3, 8'd2, 8'd1},
                px: {8'd0, 8'd1, 8'd3, 8'd0}, py: {8'd0, 8'd3, 8'd2, 8'hFF},
                s: 32'd0, h: 32'd0, c: 32'd4, e: 1'b1, lat: 5};

    // Reset state.
    #12;
    chk("reset_busy", 32'(busy_v[0]), 32'd0);
    chk("reset_done", 32'(done_v[0]), 32'd0);
    chk("reset_sum", sum_v[0], 32'd0);
    chk("reset_cycles", cyc_v[0], 32'd0);
    chk("reset_p_re", 32'(pre_v[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    for (int v = 0; v < 7; v++) begin
      load_vec(vecs[v]);
      run_eval(vecs[v].d, -1, lat);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
      chk($sformatf("v%0d_sum", v), sum_v[vecs[v].d], vecs[v].s);
      chk($sformatf("v%0d_sum_1hop", v), hop_v[vecs[v].d], vecs[v].h);
      chk($sformatf("v%0d_cycles", v), cyc_v[vecs[v].d], vecs[v].c);
      chk($sformatf("v%0d_err", v), 32'(err_v[vecs[v].d]), 32'(vecs[v].e));
      chk($sformatf("v%0d_busy_at_done", v), 32'(busy_v[vecs[v].d]), 32'd0);
    end

    // Second start while busy is ignored; start in the done cycle is ignored too.
    load_vec(vecs[0]);
    run_eval(0, 3, lat);
    chk("repulse_latency", 32'(lat), 32'd11);
    chk("repulse_sum", sum_v[0], 32'd4);
    chk("repulse_cycles", cyc_v[0], 32'd10);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("start_on_done_idle", 32'(busy_v[0]), 32'd0);
    @(negedge clk);
    chk("start_on_done_still_idle", 32'(busy_v[0]), 32'd0);
    chk("start_on_done_sum_held", sum_v[0], 32'd4);

    // Reset during POSB of edge 1 (cycle 8), then a clean rerun.
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_reset_sum_partial", sum_v[0], 32'd4);
    chk("pre_reset_p_re", 32'(pre_v[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy_v[0]), 32'd0);
    chk("midreset_done", 32'(done_v[0]), 32'd0);
    chk("midreset_err", 32'(err_v[0]), 32'd0);
    chk("midreset_sum", sum_v[0], 32'd0);
    chk("midreset_sum_1hop", hop_v[0], 32'd0);
    chk("midreset_cycles", cyc_v[0], 32'd0);
    chk("midreset_p_re", 32'(pre_v[0]), 32'd0);
    chk("midreset_p_addr", pa_v[0], 32'd0);
    chk("midreset_e_re", 32'(ere_v[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) dcount++;
    end
    chk("post_reset_quiet", 32'(dcount), 32'd0);
    run_eval(0, -1, lat);
    chk("rerun_latency", 32'(lat), 32'd11);
    chk("rerun_sum", sum_v[0], 32'd4);
    chk("rerun_sum_1hop", hop_v[0], 32'd2);
    chk("rerun_cycles", cyc_v[0], 32'd10);

    // Randomized runs on the 12-edge instance.
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < 16; k++) begin
        int x = int'($urandom_range(0, 40)) - 20;
        int y = int'($urandom_range(0, 40)) - 20;
        ea_mem[k] = int'($urandom_range(0, 15));
        eb_mem[k] = int'($urandom_range(0, 15));
        px_mem[k] = (x == -1) ? 0 : x;
        py_mem[k] = (y == -1) ? 0 : y;
      end
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) px_mem[$urandom_range(0, 15)] = -1;
        else py_mem[$urandom_range(0, 15)] = -1;
      end
      model(12, es, eh, ec, ee, elat);
      run_eval(4, -1, lat);
      chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'(elat));
      chk($sformatf("rnd%0d_sum", t), sum_v[4], es);
      chk($sformatf("rnd%0d_sum_1hop", t), hop_v[4], eh);
      chk($sformatf("rnd%0d_cycles", t), cyc_v[4], ec);
      chk($sformatf("rnd%0d_err", t), 32'(err_v[4]), 32'(ee));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
